// File: rtl/sm_dot_accumulator_pkg.sv
// Shared sign-magnitude definitions for the dot accumulator: field-slice macros,
// the zero constant and the debug view of the accumulate/output-buffer state.
`ifndef SM_DOT_ACCUMULATOR_MACROS
`define SM_DOT_ACCUMULATOR_MACROS
`define SM_MAG(w) [(w)-2:0]
`define SM_SIGN(w) [(w)-1]
`endif

package sm_dot_accumulator_pkg;

  localparam int SM_MAX_W = 64;
  localparam logic [SM_MAX_W-1:0] SM_ZERO = '0;

  // {output buffer full, partial vector in progress}
  typedef enum logic [1:0] {
    ST_EMPTY      = 2'b00,
    ST_ACCUM      = 2'b01,
    ST_FULL       = 2'b10,
    ST_FULL_ACCUM = 2'b11
  } dot_state_e;

endpackage

// File: rtl/sm_add.sv
// Combinational two-operand sign-magnitude adder with carry out.
// A -0 operand is treated as +0 and a zero result always comes out as +0.
module sm_add #(
  parameter int W = 18
) (
  input  logic         a_sign,
  input  logic [W-1:0] a_mag,
  input  logic         b_sign,
  input  logic [W-1:0] b_mag,
  output logic         s_sign,
  output logic [W-1:0] s_mag,
  output logic         s_carry
);

  logic         a_neg;
  logic         b_neg;
  logic [W:0]   sum_ext;

  always_comb begin
    a_neg   = a_sign & (a_mag != '0);
    b_neg   = b_sign & (b_mag != '0);
    sum_ext = '0;
    s_sign  = 1'b0;
    if (a_neg == b_neg) begin
      sum_ext = {1'b0, a_mag} + {1'b0, b_mag};
      s_sign  = a_neg;
    end else if (a_mag >= b_mag) begin
      sum_ext = {1'b0, a_mag - b_mag};
      s_sign  = a_neg;
    end else begin
      sum_ext = {1'b0, b_mag - a_mag};
      s_sign  = b_neg;
    end
    if (sum_ext == '0) s_sign = 1'b0;
  end

  assign s_mag   = sum_ext[W-1:0];
  assign s_carry = sum_ext[W];

endmodule

// File: rtl/sm_dot_accumulator.sv
// Multi-lane sign-magnitude accumulator: lane tree, saturating vector accumulation
// and a one-entry output buffer with valid/ready flow control.
module sm_dot_accumulator
  import sm_dot_accumulator_pkg::*;
#(
  parameter int IN_W  = 15,
  parameter int OUT_W = 19,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                  iCLK,
  input  logic                  iRSTn,
  input  logic                  iEN,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [LANES*IN_W-1:0] iData,
  input  logic                  iLast,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [OUT_W-1:0]      oSum,
  output logic [CNT_W-1:0]      oCount,
  output logic                  oSat,
  output logic [1:0]            oDbgState
);

  localparam int MAG_W = OUT_W - 1;
  localparam int TW    = MAG_W + 1;
  localparam int LVLS  = $clog2(LANES);
  localparam logic [MAG_W-1:0] MAX_MAG = '1;

  // Handshake: a beat transfers on a rising edge when iValid & oReady & iEN;
  // a result transfers when oValid & iReady. oReady = ~oValid | iReady.

  // Level 0 holds the zero-extended lanes; each further level halves the node count.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = LANES >> l;
    logic          sgn [N];
    logic [TW-1:0] mag [N];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < N; k++) begin : g_lane
        logic [IN_W-1:0] lane;
        assign lane   = iData[k*IN_W +: IN_W];
        assign sgn[k] = lane `SM_SIGN(IN_W);
        assign mag[k] = TW'(lane `SM_MAG(IN_W));
      end
    end else begin : g_add
      for (genvar n = 0; n < N; n++) begin : g_node
        logic          s_sign;
        logic          s_carry;
        logic [TW-1:0] s_mag;
        sm_add #(.W(TW)) u_add (
          .a_sign (g_lvl[l-1].sgn[2*n]),
          .a_mag  (g_lvl[l-1].mag[2*n]),
          .b_sign (g_lvl[l-1].sgn[2*n+1]),
          .b_mag  (g_lvl[l-1].mag[2*n+1]),
          .s_sign (s_sign),
          .s_mag  (s_mag),
          .s_carry(s_carry)
        );
        // A node overflow pins the node at full scale so the root clamp catches it.
        assign sgn[n] = s_sign;
        assign mag[n] = s_carry ? '1 : s_mag;
      end
    end
  end

  logic             tree_sign;
  logic [TW-1:0]    tree_mag;
  logic             tree_over;
  logic [MAG_W-1:0] lane_mag;
  logic             nxt_sign;
  logic [MAG_W-1:0] nxt_raw;
  logic             nxt_carry;
  logic [MAG_W-1:0] nxt_mag;
  logic             clamp_now;

  assign tree_sign = g_lvl[LVLS].sgn[0];
  assign tree_mag  = g_lvl[LVLS].mag[0];
  assign tree_over = tree_mag[TW-1];
  assign lane_mag  = tree_over ? MAX_MAG : tree_mag[MAG_W-1:0];

  logic             acc_sign_q, acc_sign_d;
  logic [MAG_W-1:0] acc_mag_q, acc_mag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             valid_q, valid_d;
  logic             sum_sign_q, sum_sign_d;
  logic [MAG_W-1:0] sum_mag_q, sum_mag_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  sm_add #(.W(MAG_W)) u_acc_add (
    .a_sign (acc_sign_q),
    .a_mag  (acc_mag_q),
    .b_sign (tree_sign),
    .b_mag  (lane_mag),
    .s_sign (nxt_sign),
    .s_mag  (nxt_raw),
    .s_carry(nxt_carry)
  );

  assign nxt_mag   = nxt_carry ? MAX_MAG : nxt_raw;
  assign clamp_now = tree_over | nxt_carry;

  logic             ready;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  dot_state_e       state;

  always_comb begin
    ready      = ~valid_q | iReady;
    accept     = iValid & ready & iEN;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    state      = dot_state_e'({valid_q, cnt_q != '0});
    acc_sign_d = acc_sign_q;
    acc_mag_d  = acc_mag_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    valid_d    = valid_q;
    sum_sign_d = sum_sign_q;
    sum_mag_d  = sum_mag_q;
    count_d    = count_q;
    sat_d      = sat_q;
    if (valid_q & iReady) valid_d = 1'b0;
    if (accept) begin
      if (iLast) begin
        // Closing beat refills the buffer and restarts the accumulator in one edge.
        valid_d    = 1'b1;
        sum_sign_d = nxt_sign;
        sum_mag_d  = nxt_mag;
        count_d    = cnt_inc;
        sat_d      = sticky_q | clamp_now;
        acc_sign_d = 1'b0;
        acc_mag_d  = SM_ZERO[MAG_W-1:0];
        cnt_d      = '0;
        sticky_d   = 1'b0;
      end else begin
        acc_sign_d = nxt_sign;
        acc_mag_d  = nxt_mag;
        cnt_d      = cnt_inc;
        sticky_d   = sticky_q | clamp_now;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      acc_sign_q <= 1'b0;
      acc_mag_q  <= SM_ZERO[MAG_W-1:0];
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      valid_q    <= 1'b0;
      sum_sign_q <= 1'b0;
      sum_mag_q  <= SM_ZERO[MAG_W-1:0];
      count_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      acc_sign_q <= acc_sign_d;
      acc_mag_q  <= acc_mag_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      valid_q    <= valid_d;
      sum_sign_q <= sum_sign_d;
      sum_mag_q  <= sum_mag_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
    end
  end

  assign oReady    = ready;
  assign oValid    = valid_q;
  assign oSum      = {sum_sign_q, sum_mag_q};
  assign oCount    = count_q;
  assign oSat      = sat_q;
  assign oDbgState = state;

endmodule

// File: tb/tb_sm_dot_accumulator.sv
// Directed bench for sm_dot_accumulator: integer reference model checked every cycle,
// plus hand-computed expected results consumed in order from a scoreboard queue.
module tb_sm_dot_accumulator;

  localparam int MAXM = 262143;

  logic        iCLK;
  logic        iRSTn;
  logic        iEN;
  logic        iValid;
  logic        oReady;
  logic [59:0] iData;
  logic        iLast;
  logic        oValid;
  logic        iReady;
  logic [18:0] oSum;
  logic [7:0]  oCount;
  logic        oSat;
  logic [1:0]  oDbgState;

  int n_vec = 0;
  int n_err = 0;
  logic [27:0] exp_q[$];

  sm_dot_accumulator #(.IN_W(15), .OUT_W(19), .LANES(4), .CNT_W(8)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iEN(iEN), .iValid(iValid), .oReady(oReady),
    .iData(iData), .iLast(iLast), .oValid(oValid), .iReady(iReady),
    .oSum(oSum), .oCount(oCount), .oSat(oSat), .oDbgState(oDbgState)
  );

  // ---------------- clock ----------------
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- helpers ----------------
  function automatic logic [14:0] sm(input int v);
    logic [13:0] m;
    m = 14'(v < 0 ? -v : v);
    return {(v < 0) ? 1'b1 : 1'b0, m};
  endfunction

  function automatic logic [18:0] enc(input int v);
    logic [17:0] m;
    m = 18'(v < 0 ? -v : v);
    return {(v < 0) ? 1'b1 : 1'b0, m};
  endfunction

  function automatic logic [27:0] pack(input int v, input int cnt, input logic sat);
    logic [7:0] c;
    c = 8'(cnt);
    return {enc(v), c, sat};
  endfunction

  function automatic int lane_val(input logic [14:0] x);
    int m;
    m = int'(x[13:0]);
    return x[14] ? -m : m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_acc, m_cnt, m_sum, m_count;
  logic m_sticky, m_valid, m_sat;

  always @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      m_acc = 0; m_cnt = 0; m_sticky = 0;
      m_valid = 0; m_sum = 0; m_count = 0; m_sat = 0;
    end else begin
      int   ls;
      int   nx;
      logic clamp;
      logic took;
      took = iValid && iEN && (!m_valid || iReady);
      if (m_valid && iReady) m_valid = 0;
      if (took) begin
        ls = 0;
        for (int k = 0; k < 4; k++) ls += lane_val(iData[k*15 +: 15]);
        clamp = 0;
        if (ls > MAXM) begin ls = MAXM; clamp = 1; end
        else if (ls < -MAXM) begin ls = -MAXM; clamp = 1; end
        nx = m_acc + ls;
        if (nx > MAXM) begin nx = MAXM; clamp = 1; end
        else if (nx < -MAXM) begin nx = -MAXM; clamp = 1; end
        if (iLast) begin
          m_valid = 1;
          m_sum   = nx;
          m_count = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_sat   = m_sticky | clamp;
          m_acc = 0; m_cnt = 0; m_sticky = 0;
        end else begin
          m_acc    = nx;
          m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_sticky = m_sticky | clamp;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge iCLK) begin
    if (iRSTn) begin
      chk("oReady", 32'(oReady), 32'(!m_valid || iReady));
      chk("oValid", 32'(oValid), 32'(m_valid));
      if (m_valid) begin
        chk("oSum", 32'(oSum), 32'(enc(m_sum)));
        chk("oCount", 32'(oCount), 32'(m_count));
        chk("oSat", 32'(oSat), 32'(m_sat));
      end
    end
  end

  // ---------------- scoreboard of hand-computed results ----------------
  always @(negedge iCLK) begin
    if (iRSTn && oValid && iReady) begin
      logic [27:0] e;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_result: got %0h want none", {oSum, oCount, oSat});
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'({oSum, oCount, oSat}), 32'(e));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input int l0, input int l1, input int l2, input int l3,
                           input logic last);
    int   guard;
    logic took;
    guard = 0;
    took  = 0;
    iValid = 1'b1;
    iData  = {sm(l3), sm(l2), sm(l1), sm(l0)};
    iLast  = last;
    while (!took && guard < 50) begin
      @(negedge iCLK);
      took = oReady && iEN;
      @(posedge iCLK);
      #1;
      guard++;
    end
    if (!took) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: got no accept want accept within 50 cycles");
    end
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      @(posedge iCLK);
      g++;
    end
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_oValid"}, 32'(oValid), 32'd0);
    chk({tag, "_oSum"}, 32'(oSum), 32'd0);
    chk({tag, "_oCount"}, 32'(oCount), 32'd0);
    chk({tag, "_oSat"}, 32'(oSat), 32'd0);
    chk({tag, "_oReady"}, 32'(oReady), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    iRSTn = 1'b0; iEN = 1'b1; iValid = 1'b0; iData = '0; iLast = 1'b0; iReady = 1'b1;
    #12;
    chk_zero_outputs("reset");
    @(posedge iCLK); #1;
    iRSTn = 1'b1;

    // mixed-sign lanes, single beat
    exp_q.push_back(pack(4, 1, 1'b0));
    send_beat(3, -5, 7, -1, 1'b1);
    wait_idle();

    // cancellation including a -0 lane must give +0
    exp_q.push_back(28'h0000002);
    iValid = 1'b1;
    send_beat(100, -100, 0, 0, 1'b1);
    wait_idle();
    exp_q.push_back(28'h0000002);
    iValid = 1'b1; iData = {15'h4000, 15'h0000, sm(-100), sm(100)}; iLast = 1'b1;
    @(negedge iCLK); @(posedge iCLK); #1;
    iValid = 1'b0; iLast = 1'b0;
    wait_idle();

    // negative result
    exp_q.push_back(pack(-8, 1, 1'b0));
    send_beat(-7, -2, 1, 0, 1'b1);
    wait_idle();

    // positive saturation over 5 beats, then a clean vector clears oSat
    exp_q.push_back(pack(MAXM, 5, 1'b1));
    for (int b = 0; b < 5; b++) send_beat(16383, 16383, 16383, 16383, b == 4);
    exp_q.push_back(pack(1, 1, 1'b0));
    send_beat(1, 0, 0, 0, 1'b1);
    wait_idle();

    // negative saturation keeps the sign
    exp_q.push_back(pack(-MAXM, 5, 1'b1));
    for (int b = 0; b < 5; b++) send_beat(-16383, -16383, -16383, -16383, b == 4);
    wait_idle();

    // back-to-back vectors with the first result held for 3 cycles
    exp_q.push_back(pack(36, 2, 1'b0));
    exp_q.push_back(pack(-29, 2, 1'b0));
    iReady = 1'b0;
    fork
      begin
        send_beat(1, 2, 3, 4, 1'b0);
        send_beat(5, 6, 7, 8, 1'b1);
        send_beat(-10, 0, 0, 0, 1'b0);
        send_beat(-20, 1, 0, 0, 1'b1);
      end
      begin
        int g;
        g = 0;
        while (!oValid && g < 40) begin @(negedge iCLK); g++; end
        repeat (3) @(posedge iCLK);
        #1;
        iReady = 1'b1;
      end
    join
    wait_idle();

    // iEN low for 2 cycles mid-vector with iValid held high
    exp_q.push_back(pack(99, 3, 1'b0));
    send_beat(10, 20, 30, 40, 1'b0);
    iValid = 1'b1; iData = {sm(0), sm(0), sm(0), sm(-5)}; iLast = 1'b0; iEN = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    iEN = 1'b1;
    send_beat(-5, 0, 0, 0, 1'b0);
    send_beat(1, 1, 1, 1, 1'b1);
    wait_idle();

    // reset after 3 beats of a vector: partial sum discarded
    exp_q.push_back(pack(5, 1, 1'b0));
    send_beat(5, 0, 0, 0, 1'b1);
    wait_idle();
    for (int b = 0; b < 3; b++) send_beat(1000, 1000, 1000, 1000, 1'b0);
    iRSTn = 1'b0;
    #2;
    chk_zero_outputs("midreset");
    @(posedge iCLK); #1;
    iRSTn = 1'b1;
    exp_q.push_back(pack(8, 1, 1'b0));
    send_beat(2, 2, 2, 2, 1'b1);
    wait_idle();

    repeat (3) @(posedge iCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
